pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer for the fetch stage.
- Drives the 3-bit select of the 8-way PC-source mux, takes the mux output back, and registers it as the architectural fetch PC.
- Owns the redirect priority and the post-redirect flush window.
- Raises fetch_valid/flush toward the instruction-fetch and decode stages.

Parameters:
- WIDTH, 32, width of the PC and of the mux data path.
- RESET_VECTOR, 32'h0000_0000, PC value loaded while booting.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  downstream hazard; hold the current PC.
- branch_taken  input  1  EX-stage conditional branch resolved taken.
- jal  input  1  EX-stage JAL.
- jalr  input  1  EX-stage JALR.
- trap_req  input  1  exception or interrupt request.
- mret  input  1  return from trap.
- pc_mux_out  input  WIDTH  selected next PC returned from the 8-way mux.
- pc_sel  output  3  mux select: 0 PC+4, 1 branch target, 2 JAL target, 3 JALR target, 4 trap vector, 5 mepc, 6 hold (current pc), 7 RESET_VECTOR.
- pc  output  WIDTH  registered fetch PC.
- fetch_valid  output  1  the pc value is a fetch to be issued this cycle.
- flush  output  1  squash younger in-flight instructions.

Behaviour:
- Clock/reset: one clock (clk). rst is synchronous and active-high. Reset state: state=BOOT, pc=RESET_VECTOR, flush_cnt=0.
- Outputs while rst=1 and in the first cycle after reset: pc_sel=7, fetch_valid=0, flush=0.
- pc register: pc <= pc_mux_out on every non-reset edge. Holding the PC is done only by selecting 6; there is no separate enable.
- pc_sel is combinational from the state and the inputs. It is 7 whenever rst=1 or state=BOOT.
- State BOOT:
  - pc_sel=7, fetch_valid=0, flush=0.
  - Next state is RUN unconditionally. All redirect and stall inputs are ignored.
- State RUN, pc_sel priority: trap_req (4) > mret (5) > jalr (3) > jal (2) > branch_taken (1) > stall (6) > default (0).
  - Redirects override stall.
  - Any redirect (sel 1..5) moves the state to FLUSH and loads flush_cnt=FLUSH_CYCLES.
  - fetch_valid = 1 when no redirect and stall=0. Otherwise fetch_valid = 0.
  - flush=0.
- State FLUSH:
  - flush=1 and fetch_valid=0.
  - pc_sel=6 if stall, else 0, so fetch proceeds down the new path.
  - flush_cnt decrements each cycle. When it reaches 1, the next state is RUN.
  - Because of this, flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect.
- Inside FLUSH:
  - mret, jalr, jal and branch_taken are ignored; they come from squashed instructions.
  - trap_req is honoured: pc_sel=4, flush_cnt reloads to FLUSH_CYCLES, state stays FLUSH.
- Simultaneous events: the highest-priority redirect wins. The others are dropped and never replayed.
- Reset mid-flush or mid-stall: state returns to BOOT and flush_cnt is cleared. flush drops to 0 in the cycle after the reset edge.
- pc_mux_out wraps naturally (PC+4 at 32'hFFFF_FFFC gives 0). The block does no arithmetic on the PC.
- Illegal state encoding: treated as BOOT.

Test Plan:
Bench mux model: d0=pc+4, d1=32'h200, d2=32'h300, d3=32'h400, d4=32'h800, d5=32'h900, d6=pc, d7=RESET_VECTOR.
1. Assert rst 2 cycles, then release with no other inputs -> pc_sel=7 in the BOOT cycle and pc=0; then pc reads 0,4,8,C on the following edges with fetch_valid=1.
2. In RUN at pc=8, assert stall for 3 cycles -> pc_sel=6, pc stays 8, fetch_valid=0; after release pc=C.
3. branch_taken and jal high together in RUN -> pc_sel=2, next pc=300. flush=1 for exactly 2 cycles while pc goes 304, 308. A branch_taken pulse during FLUSH is ignored.
4. jalr redirect, then trap_req on the 1st FLUSH cycle -> pc=400, then pc=800. flush stays high for 2 further cycles, 3 total.
5. trap_req, mret and stall all high in RUN -> pc_sel=4, pc=800. The mret is not replayed.
6. Assert rst during FLUSH -> next cycle state=BOOT, flush=0, pc=RESET_VECTOR, pc_sel=7.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the PC-source mux input, registers the chosen PC,
// and owns redirect priority plus the post-redirect flush window.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jal,
    input  logic             jalr,
    input  logic             trap_req,
    input  logic             mret,
    input  logic [WIDTH-1:0] pc_mux_out,
    output logic [2:0]       pc_sel,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_valid,
    output logic             flush
);

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JAL    = 3'd2;
    localparam logic [2:0] SEL_JALR   = 3'd3;
    localparam logic [2:0] SEL_TRAP   = 3'd4;
    localparam logic [2:0] SEL_MEPC   = 3'd5;
    localparam logic [2:0] SEL_HOLD   = 3'd6;
    localparam logic [2:0] SEL_RESET  = 3'd7;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [WIDTH-1:0] pc_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_sel      = SEL_RESET;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (trap_req)          pc_sel = SEL_TRAP;
                    else if (mret)         pc_sel = SEL_MEPC;
                    else if (jalr)         pc_sel = SEL_JALR;
                    else if (jal)          pc_sel = SEL_JAL;
                    else if (branch_taken) pc_sel = SEL_BRANCH;
                    else if (stall)        pc_sel = SEL_HOLD;
                    else                   pc_sel = SEL_SEQ;
                    fetch_valid = (pc_sel == SEL_SEQ);
                    if (pc_sel != SEL_SEQ && pc_sel != SEL_HOLD) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    // Only a trap survives the window; other redirects belong to squashed work.
                    if (trap_req) begin
                        pc_sel      = SEL_TRAP;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        pc_sel      = stall ? SEL_HOLD : SEL_SEQ;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        if (flush_cnt_q <= 3'd1) state_d = RUN;
                    end
                end
                default: begin
                    pc_sel  = SEL_RESET;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            flush_cnt_q <= 3'd0;
            pc_q        <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pc_q        <= pc_mux_out;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the fetch scenarios, then random
// redirect/stall traffic compared against a cycle-level model of the sequencer rules.
module tb_pc_sequencer;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          FC    = 2;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jal, jalr, trap_req, mret;
    logic [31:0] pc_mux_out, pc;
    logic [2:0]  pc_sel;
    logic        fetch_valid, flush;

    int checks = 0;
    int errors = 0;

    // Reference model state: booting flag, remaining flush cycles, architectural PC.
    bit          m_boot;
    int          m_flush_left;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(WIDTH), .RESET_VECTOR(RV), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jal(jal),
        .jalr(jalr), .trap_req(trap_req), .mret(mret), .pc_mux_out(pc_mux_out),
        .pc_sel(pc_sel), .pc(pc), .fetch_valid(fetch_valid), .flush(flush)
    );

    function automatic logic [31:0] mux(input logic [2:0] s, input logic [31:0] cur);
        case (s)
            3'd0:    return cur + 32'd4;
            3'd1:    return 32'h200;
            3'd2:    return 32'h300;
            3'd3:    return 32'h400;
            3'd4:    return 32'h800;
            3'd5:    return 32'h900;
            3'd6:    return cur;
            default: return RV;
        endcase
    endfunction

    always_comb pc_mux_out = mux(pc_sel, pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare combinational and registered outputs, advance model.
    task automatic step(input bit r, input bit st, input bit br, input bit jl,
                        input bit jr, input bit tr, input bit mr);
        logic [2:0] e_sel;
        bit         e_fv, e_fl;
        @(negedge clk);
        rst = r; stall = st; branch_taken = br; jal = jl; jalr = jr; trap_req = tr; mret = mr;
        #1;
        e_fv = 1'b0;
        e_fl = 1'b0;
        if (r || m_boot) begin
            e_sel = 3'd7;
        end else if (m_flush_left > 0) begin
            e_fl  = 1'b1;
            e_sel = tr ? 3'd4 : (st ? 3'd6 : 3'd0);
        end else begin
            e_sel = tr ? 3'd4 : mr ? 3'd5 : jr ? 3'd3 : jl ? 3'd2 : br ? 3'd1 : st ? 3'd6 : 3'd0;
            e_fv  = (e_sel == 3'd0);
        end
        chk("pc", pc, m_pc);
        chk("pc_sel", {29'd0, pc_sel}, {29'd0, e_sel});
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
        chk("flush", {31'd0, flush}, {31'd0, e_fl});
        @(posedge clk);
        #1;
        if (r) begin
            m_boot       = 1'b1;
            m_flush_left = 0;
            m_pc         = RV;
        end else begin
            m_pc = mux(e_sel, m_pc);
            if (m_boot)                              m_boot = 1'b0;
            else if (m_flush_left > 0)               m_flush_left = tr ? FC : m_flush_left - 1;
            else if (e_sel >= 3'd1 && e_sel <= 3'd5) m_flush_left = FC;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stall = 0; branch_taken = 0; jal = 0; jalr = 0; trap_req = 0; mret = 0;
        m_boot = 1'b1; m_flush_left = 0; m_pc = RV;
        @(posedge clk); #1;

        // 1: reset, boot, sequential fetch
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_rst_pc", pc, 32'h0);
        idle(3);
        chk("t1_pc8", pc, 32'h8);

        // 2: stall holds
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        chk("t2_hold", pc, 32'h8);
        idle(1);
        chk("t2_release", pc, 32'hC);

        // 3: branch+jal -> jal wins, branch during flush ignored
        step(0, 0, 1, 1, 0, 0, 0);
        chk("t3_jal", pc, 32'h300);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("t3_ignored_br", pc, 32'h304);
        idle(1);
        chk("t3_pc", pc, 32'h308);
        chk("t3_flush_done", {31'd0, flush}, 32'd0);

        // 4: jalr then trap on first flush cycle stretches the window
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t4_jalr", pc, 32'h400);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("t4_trap", pc, 32'h800);
        idle(3);

        // 5: trap beats mret and stall, mret not replayed
        step(0, 1, 0, 0, 0, 1, 1);
        chk("t5_trap", pc, 32'h800);
        idle(1);
        chk("t5_no_mret", pc, 32'h804);

        // 6: reset mid-flush
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_pc", pc, RV);
        chk("t6_flush", {31'd0, flush}, 32'd0);
        chk("t6_sel", {29'd0, pc_sel}, 32'd7);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 23) == 0),
                 ($urandom_range(0, 23) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
